// File: rtl/poly_feeder_pkg.sv
// -----------------------------------------------------------------------------
// poly_feeder_pkg
// Shared Kyber constants, coefficient widths, the feeder state encoding and the
// coefficient-store helper used by poly_feeder.
//
// Build option: POLY_FEEDER_REDUCE_EN
//   defined   -> stored value is v-3329 when v >= 3329, else v
//   undefined -> stored value is v unmodified (no subtractor built)
// -----------------------------------------------------------------------------
package poly_feeder_pkg;

   localparam int unsigned COEF_W = 16;
   localparam int unsigned VAL_W  = 12;

   localparam logic [VAL_W-1:0] KYBER_Q = 12'd3329;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_KICK  = 2'd3
   } state_t;

   // Convert the 12-bit input value into the 16-bit word kept in the buffer.
   // A 12-bit value is always below 2q, so one conditional subtract suffices.
   function automatic logic [COEF_W-1:0] coef_store(input logic [VAL_W-1:0] v);
      logic [COEF_W-1:0] res;
`ifdef POLY_FEEDER_REDUCE_EN
      if (v >= KYBER_Q) begin
         res = {4'd0, v - KYBER_Q};
      end else begin
         res = {4'd0, v};
      end
`else
      res = {4'd0, v};
`endif
      return res;
   endfunction

   // True when any of the reserved upper bits of a coefficient word is set.
   function automatic logic coef_has_junk(input logic [COEF_W-1:0] w);
      return (w[COEF_W-1:VAL_W] != 4'd0);
   endfunction

endpackage : poly_feeder_pkg

// File: rtl/poly_feeder_buf.sv
// -----------------------------------------------------------------------------
// poly_buf
// N x 16 coefficient buffer (N = 2^DEPTH) with one write port and two
// registered read ports returning the even/odd pair at addresses 2k and 2k+1.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset (clears read regs)
//   wr_en/wr_addr/wr_data   write port
//   rd_en           load the read registers this cycle (otherwise they hold)
//   rd_addr_even    even address 2k of the pair to read
//   rd_even/rd_odd  registered words at 2k and 2k+1
// -----------------------------------------------------------------------------
module poly_buf
   import poly_feeder_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DEPTH-1:0]  wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [DEPTH-1:0]  rd_addr_even,
   output logic [COEF_W-1:0] rd_even,
   output logic [COEF_W-1:0] rd_odd
);

   localparam int unsigned N = 1 << DEPTH;

   logic [COEF_W-1:0] mem_q [N];
   logic [DEPTH-1:0]  rd_addr_odd;
   logic [COEF_W-1:0] rd_even_d, rd_even_q;
   logic [COEF_W-1:0] rd_odd_d,  rd_odd_q;

   assign rd_addr_odd = {rd_addr_even[DEPTH-1:1], 1'b1};

   // Storage array; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read data with write-forwarding so a pair may be read in the same cycle
   // its last word is written (matters only for very small DEPTH).
   always_comb begin
      rd_even_d = mem_q[rd_addr_even];
      rd_odd_d  = mem_q[rd_addr_odd];
      if (wr_en && (wr_addr == rd_addr_even)) begin
         rd_even_d = wr_data;
      end else begin
         rd_even_d = mem_q[rd_addr_even];
      end
      if (wr_en && (wr_addr == rd_addr_odd)) begin
         rd_odd_d = wr_data;
      end else begin
         rd_odd_d = mem_q[rd_addr_odd];
      end
   end

   // Read registers: load on rd_en, otherwise hold the last pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_even_q <= 16'd0;
         rd_odd_q  <= 16'd0;
      end else if (rd_en) begin
         rd_even_q <= rd_even_d;
         rd_odd_q  <= rd_odd_d;
      end
   end

   assign rd_even = rd_even_q;
   assign rd_odd  = rd_odd_q;

endmodule : poly_buf

// File: rtl/poly_feeder.sv
// -----------------------------------------------------------------------------
// poly_feeder
// Collects N = 2^DEPTH coefficients over a valid/ready input, then streams them
// to a downstream NTT as N/2 back-to-back (odd, even, index) pairs and finally
// pulses ntt_set for one cycle.  FSM: IDLE -> FILL -> DRAIN -> KICK -> IDLE.
//
// Build option: POLY_FEEDER_REDUCE_EN (conditional subtract of q on store).
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   start                    load request, honoured only in IDLE
//   in_valid/in_ready/in_coef coefficient input handshake
//   readin                   pair valid on ntt_din_1/ntt_din_2/in_index
//   ntt_din_1/ntt_din_2      odd / even coefficient of the pair
//   in_index                 even index of the pair
//   ntt_set                  one-cycle start pulse to the NTT
//   busy                     high outside IDLE
//   err                      sticky: reserved bits seen since last start
// -----------------------------------------------------------------------------
module poly_feeder
   import poly_feeder_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COEF_W-1:0] in_coef,
   output logic              readin,
   output logic [COEF_W-1:0] ntt_din_1,
   output logic [COEF_W-1:0] ntt_din_2,
   output logic [DEPTH-1:0]  in_index,
   output logic              ntt_set,
   output logic              busy,
   output logic              err
);

   localparam logic [DEPTH-1:0] WPTR_LAST = DEPTH'((1 << DEPTH) - 1);
   localparam logic [DEPTH-1:0] PAIR_LAST = DEPTH'((1 << (DEPTH - 1)) - 1);

   state_t            state_d, state_q;
   logic [DEPTH-1:0]  wptr_d, wptr_q;
   logic [DEPTH-1:0]  pair_d, pair_q;
   logic [DEPTH-1:0]  index_d, index_q;
   logic              in_ready_d, in_ready_q;
   logic              readin_d, readin_q;
   logic              ntt_set_d, ntt_set_q;
   logic              busy_d, busy_q;
   logic              err_d, err_q;

   logic              accept;
   logic              rd_en;
   logic [DEPTH-1:0]  rd_addr;
   logic [DEPTH-1:0]  pair_next;
   logic [DEPTH-1:0]  index_next;
   logic [COEF_W-1:0] wr_data;

   assign accept     = (state_q == ST_FILL) && in_valid && in_ready_q;
   assign wr_data    = coef_store(in_coef[VAL_W-1:0]);
   assign pair_next  = pair_q + 1'b1;
   assign index_next = DEPTH'({pair_next, 1'b0});

   // Next-state and next-output logic; outputs are computed for the coming
   // state so every output comes straight from a flop.
   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      pair_d     = pair_q;
      index_d    = index_q;
      in_ready_d = in_ready_q;
      readin_d   = readin_q;
      ntt_set_d  = 1'b0;
      busy_d     = busy_q;
      err_d      = err_q;
      rd_en      = 1'b0;
      rd_addr    = index_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_FILL;
               wptr_d     = {DEPTH{1'b0}};
               pair_d     = {DEPTH{1'b0}};
               err_d      = 1'b0;
               in_ready_d = 1'b1;
               busy_d     = 1'b1;
            end else begin
               state_d    = ST_IDLE;
            end
         end

         ST_FILL: begin
            if (accept) begin
               wptr_d = wptr_q + 1'b1;
               if (coef_has_junk(in_coef)) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               // Last word: prefetch pair 0 so it is on the outputs next cycle.
               if (wptr_q == WPTR_LAST) begin
                  state_d    = ST_DRAIN;
                  in_ready_d = 1'b0;
                  pair_d     = {DEPTH{1'b0}};
                  index_d    = {DEPTH{1'b0}};
                  rd_en      = 1'b1;
                  rd_addr    = {DEPTH{1'b0}};
                  readin_d   = 1'b1;
               end else begin
                  state_d    = ST_FILL;
               end
            end else begin
               state_d = ST_FILL;
            end
         end

         ST_DRAIN: begin
            if (pair_q == PAIR_LAST) begin
               state_d   = ST_KICK;
               readin_d  = 1'b0;
               ntt_set_d = 1'b1;
            end else begin
               pair_d    = pair_next;
               index_d   = index_next;
               rd_en     = 1'b1;
               rd_addr   = index_next;
               readin_d  = 1'b1;
            end
         end

         ST_KICK: begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            readin_d  = 1'b0;
         end

         default: begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b0;
            readin_d   = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wptr_q     <= {DEPTH{1'b0}};
         pair_q     <= {DEPTH{1'b0}};
         index_q    <= {DEPTH{1'b0}};
         in_ready_q <= 1'b0;
         readin_q   <= 1'b0;
         ntt_set_q  <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         pair_q     <= pair_d;
         index_q    <= index_d;
         in_ready_q <= in_ready_d;
         readin_q   <= readin_d;
         ntt_set_q  <= ntt_set_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   poly_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (accept),
      .wr_addr      (wptr_q),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_addr_even (rd_addr),
      .rd_even      (ntt_din_2),
      .rd_odd       (ntt_din_1)
   );

   assign in_ready = in_ready_q;
   assign readin   = readin_q;
   assign in_index = index_q;
   assign ntt_set  = ntt_set_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule : poly_feeder

// File: tb/tb_poly_feeder.sv
// -----------------------------------------------------------------------------
// tb_poly_feeder
// Self-checking bench for poly_feeder (DEPTH = 4).  Expected pairs are queued
// when a polynomial is loaded and popped by a monitor on each readin cycle.
// Reduction-dependent expectations follow POLY_FEEDER_REDUCE_EN.
// -----------------------------------------------------------------------------
module tb_poly_feeder;

   localparam int DEPTH = 4;
   localparam int N     = 16;

`ifdef POLY_FEEDER_REDUCE_EN
   localparam bit RED = 1'b1;
`else
   localparam bit RED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_coef;
   logic        readin;
   logic [15:0] ntt_din_1;
   logic [15:0] ntt_din_2;
   logic [3:0]  in_index;
   logic        ntt_set;
   logic        busy;
   logic        err;

   poly_feeder #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coef   (in_coef),
      .readin    (readin),
      .ntt_din_1 (ntt_din_1),
      .ntt_din_2 (ntt_din_2),
      .in_index  (in_index),
      .ntt_set   (ntt_set),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d1;
      logic [15:0] d2;
      logic [3:0]  idx;
   } pair_t;

   typedef struct {
      logic [3:0]  pos;
      logic [15:0] coef;
      logic [15:0] exp_val;
      logic        exp_err;
   } vec_t;

   pair_t exp_q[$];
   vec_t  tbl[8];

   int   checks      = 0;
   int   errors      = 0;
   int   readin_cnt  = 0;
   int   readin_rise = 0;
   int   kick_cnt    = 0;
   logic prev_readin = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every presented pair against the scoreboard.
   always @(negedge clk) begin
      pair_t p;
      if (readin === 1'b1) begin
         readin_cnt++;
         if (!prev_readin) readin_rise++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pair actual=%0d/%0d/%0d required=none", ntt_din_1, ntt_din_2, in_index);
         end else begin
            p = exp_q.pop_front();
            chk("pair_din_1", {16'd0, ntt_din_1}, {16'd0, p.d1});
            chk("pair_din_2", {16'd0, ntt_din_2}, {16'd0, p.d2});
            chk("pair_index", {28'd0, in_index}, {28'd0, p.idx});
         end
      end
      if (ntt_set === 1'b1) begin
         kick_cnt++;
         chk("kick_after_last_pair", {31'd0, prev_readin}, 32'd1);
         chk("readin_low_in_kick", {31'd0, readin}, 32'd0);
      end
      prev_readin = readin;
   end

   // Load one polynomial c[], expecting stored values e[]; called at posedge+1.
   task automatic run_load(input logic [15:0] c[N], input logic [15:0] e[N],
                           input bit gaps, input bit start_in_drain);
      int rc0, rr0, kc0, i, guard;
      bit acc;
      pair_t p;
      rc0 = readin_cnt;
      rr0 = readin_rise;
      kc0 = kick_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_clear_on_start", {31'd0, err}, 32'd0);
      chk("in_ready_fill", {31'd0, in_ready}, 32'd1);
      chk("busy_fill", {31'd0, busy}, 32'd1);
      for (int k = 0; k < N / 2; k++) begin
         p.d1  = e[2 * k + 1];
         p.d2  = e[2 * k];
         p.idx = 4'(2 * k);
         exp_q.push_back(p);
      end
      i = 0;
      guard = 0;
      while (i < N && guard < 200) begin
         in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_coef  = c[i];
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         guard++;
         if (acc) i++;
      end
      in_valid = 1'b0;
      in_coef  = 16'd0;
      chk("fill_complete", i, N);
      chk("first_pair_latency", {31'd0, readin}, 32'd1);
      chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
      if (start_in_drain) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      guard = 0;
      while (busy !== 1'b0 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("readin_cycles", readin_cnt - rc0, N / 2);
      chk("readin_bursts", readin_rise - rr0, 1);
      chk("ntt_set_pulses", kick_cnt - kc0, 1);
      chk("queue_empty", exp_q.size(), 0);
      chk("hold_din_1", {16'd0, ntt_din_1}, {16'd0, e[N - 1]});
      chk("hold_din_2", {16'd0, ntt_din_2}, {16'd0, e[N - 2]});
      chk("hold_index", {28'd0, in_index}, 32'd14);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] c[N];
      logic [15:0] e[N];
      int rc0, kc0;

      tbl[0] = '{4'd0,  16'd3329, RED ? 16'd0   : 16'd3329, 1'b0};
      tbl[1] = '{4'd1,  16'd4095, RED ? 16'd766 : 16'd4095, 1'b0};
      tbl[2] = '{4'd15, 16'd3328, 16'd3328,                 1'b0};
      tbl[3] = '{4'd5,  16'h1005, 16'd5,                    1'b1};
      tbl[4] = '{4'd8,  16'hF000, 16'd0,                    1'b1};
      tbl[5] = '{4'd14, 16'h1D01, RED ? 16'd0   : 16'd3329, 1'b1};
      tbl[6] = '{4'd9,  16'h0CFF, 16'd3327,                 1'b0};
      tbl[7] = '{4'd4,  16'd3330, RED ? 16'd1   : 16'd3330, 1'b0};

      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_coef  = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_readin",   {31'd0, readin},   32'd0);
      chk("rst_ntt_set",  {31'd0, ntt_set},  32'd0);
      chk("rst_busy",     {31'd0, busy},     32'd0);
      chk("rst_err",      {31'd0, err},      32'd0);
      chk("rst_din_1",    {16'd0, ntt_din_1}, 32'd0);
      chk("rst_din_2",    {16'd0, ntt_din_2}, 32'd0);
      chk("rst_index",    {28'd0, in_index},  32'd0);
      #2 reset = 1'b1;
      @(posedge clk); #1;

      // Sequential ramp 0..15, back to back.
      for (int i = 0; i < N; i++) begin
         c[i] = 16'(i);
         e[i] = 16'(i);
      end
      run_load(c, e, 1'b0, 1'b0);

      // Boundary values around q at indices 0..2.
      c[0] = 16'd3329; e[0] = RED ? 16'd0 : 16'd3329;
      c[1] = 16'd4095; e[1] = RED ? 16'd766 : 16'd4095;
      c[2] = 16'd3328; e[2] = 16'd3328;
      run_load(c, e, 1'b0, 1'b0);

      // Table: one special coefficient per polynomial, filler elsewhere.
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < N; i++) begin
            c[i] = 16'(i * 199 + 11);
            e[i] = 16'(i * 199 + 11);
         end
         c[tbl[v].pos] = tbl[v].coef;
         e[tbl[v].pos] = tbl[v].exp_val;
         run_load(c, e, v[0], (v == 3) || (v == 5));
         chk("table_err", {31'd0, err}, {31'd0, tbl[v].exp_err});
      end

      // Ramp again so the outputs hold nonzero values before the abort.
      for (int i = 0; i < N; i++) begin
         c[i] = 16'(i);
         e[i] = 16'(i);
      end
      run_load(c, e, 1'b0, 1'b0);

      // Abort mid-fill after 7 accepted words.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_coef  = 16'(100 + i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rc0 = readin_cnt;
      kc0 = kick_cnt;
      #2 reset = 1'b0;
      #1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      chk("abort_busy",     {31'd0, busy},     32'd0);
      chk("abort_readin",   {31'd0, readin},   32'd0);
      chk("abort_din_1",    {16'd0, ntt_din_1}, 32'd0);
      chk("abort_din_2",    {16'd0, ntt_din_2}, 32'd0);
      chk("abort_index",    {28'd0, in_index},  32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("abort_no_pairs",   readin_cnt - rc0, 0);
      chk("abort_no_ntt_set", kick_cnt - kc0, 0);
      run_load(c, e, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_poly_feeder
